phy_rx_lanes: RTL and testbench

- Parametrised, single-clock successor of the PHY receive path.
- Takes one serial bit stream and finds byte alignment by hunting for a COMMA symbol, then declares link lock after LOCK_COUNT consecutive aligned commas.
- Once locked, distributes data bytes round-robin over NUM_LANES parallel lanes and flags idle symbols.
- Replaces the multi-clock serial-to-parallel / demux chain with one bit-rate clock and internal byte strobes.

---
 rtl/phy_rx_lanes.sv | 149 ++++++++++++++
 tb/tb_phy_rx_lanes.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/phy_rx_lanes.sv
// phy_rx_lanes: single-clock PHY receive path.
// Hunts for byte alignment on a serial stream using a COMMA symbol, declares
// lock after LOCK_COUNT consecutive aligned commas, then distributes data
// bytes round-robin over NUM_LANES lanes and flags IDLE/COMMA symbols.
// Optional build macro PHY_RX_LOCK_LOSS_EN: a comma seen at the wrong bit
// phase while ACTIVE pulses lock_err and forces re-alignment.
//
// Handshake: valid_out[i] is a one-cycle strobe with no back-pressure; lane i
// of data_out is stable from that strobe until lane i is written again.
// frame_valid strobes together with the write of the last lane.
module phy_rx_lanes #(
    parameter int              WIDTH      = 8,
    parameter int              NUM_LANES  = 4,
    parameter int              LOCK_COUNT = 4,
    parameter logic [WIDTH-1:0] COMMA     = 8'hBC,
    parameter logic [WIDTH-1:0] IDLE      = 8'h7C
) (
    input  logic                       clk_32f,
    input  logic                       rst_L,
    input  logic                       data_in,
    output logic                       active,
    output logic                       idle_out,
    output logic [NUM_LANES*WIDTH-1:0] data_out,
    output logic [NUM_LANES-1:0]       valid_out,
    output logic                       frame_valid,
    output logic                       lock_err,
    output logic [1:0]                 state_dbg
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int LC_W  = $clog2(LOCK_COUNT + 1);

    localparam logic [1:0] SEARCH  = 2'd0;
    localparam logic [1:0] LOCKING = 2'd1;
    localparam logic [1:0] ACTIVE  = 2'd2;

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [CNT_W-1:0] bit_cnt;
    logic [LC_W-1:0]  comma_cnt;
    logic [PTR_W-1:0] ptr;
    logic [1:0]       state;
    logic             lock_err_r;
    logic             at_bnd;
    logic             is_comma;
    logic             is_idle;

    // Symbol currently completing and its classification
    always_comb begin
        sr_next  = {sr[WIDTH-2:0], data_in};
        at_bnd   = (bit_cnt == CNT_W'(WIDTH - 1));
        is_comma = (sr_next == COMMA);
        is_idle  = (sr_next == IDLE);
    end

    assign state_dbg = state;

`ifdef PHY_RX_LOCK_LOSS_EN
    assign lock_err = lock_err_r;
`else
    assign lock_err = 1'b0;
`endif

    // Alignment FSM, lane distribution and all registered outputs
    always_ff @(posedge clk_32f or negedge rst_L) begin
        if (!rst_L) begin
            sr          <= '0;
            bit_cnt     <= '0;
            comma_cnt   <= '0;
            ptr         <= '0;
            state       <= SEARCH;
            active      <= 1'b0;
            idle_out    <= 1'b0;
            data_out    <= '0;
            valid_out   <= '0;
            frame_valid <= 1'b0;
            lock_err_r  <= 1'b0;
        end else begin
            sr          <= sr_next;
            valid_out   <= '0;
            frame_valid <= 1'b0;
            lock_err_r  <= 1'b0;
            bit_cnt     <= at_bnd ? '0 : bit_cnt + CNT_W'(1);
            case (state)
                SEARCH: begin
                    // Any bit phase may carry the comma; it defines alignment
                    if (is_comma) begin
                        bit_cnt   <= '0;
                        comma_cnt <= LC_W'(1);
                        if (LOCK_COUNT == 1) begin
                            state  <= ACTIVE;
                            active <= 1'b1;
                        end else begin
                            state <= LOCKING;
                        end
                    end
                end
                LOCKING: begin
                    if (at_bnd) begin
                        if (is_comma) begin
                            comma_cnt <= comma_cnt + LC_W'(1);
                            if (comma_cnt == LC_W'(LOCK_COUNT - 1)) begin
                                state  <= ACTIVE;
                                active <= 1'b1;
                            end
                        end else begin
                            state     <= SEARCH;
                            comma_cnt <= '0;
                        end
                    end
                end
                ACTIVE: begin
                    if (at_bnd) begin
                        if (is_comma || is_idle) begin
                            idle_out <= 1'b1;
                        end else begin
                            idle_out                      <= 1'b0;
                            data_out[ptr*WIDTH +: WIDTH]  <= sr_next;
                            valid_out[ptr]                <= 1'b1;
                            if (ptr == PTR_W'(NUM_LANES - 1)) begin
                                frame_valid <= 1'b1;
                                ptr         <= '0;
                            end else begin
                                ptr <= ptr + PTR_W'(1);
                            end
                        end
                    end
`ifdef PHY_RX_LOCK_LOSS_EN
                    else if (is_comma) begin
                        // Comma at the wrong phase: realign on it, keep lane data
                        lock_err_r <= 1'b1;
                        active     <= (LOCK_COUNT == 1);
                        idle_out   <= 1'b0;
                        ptr        <= '0;
                        bit_cnt    <= '0;
                        comma_cnt  <= LC_W'(1);
                        state      <= (LOCK_COUNT == 1) ? ACTIVE : LOCKING;
                    end
`endif
                end
                default: begin
                    state <= SEARCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phy_rx_lanes.sv
// tb_phy_rx_lanes: directed bench for phy_rx_lanes with a lane-write scoreboard.
// Honours PHY_RX_LOCK_LOSS_EN when the design is built with it.
module tb_phy_rx_lanes;

    logic        clk_32f;
    logic        rst_L;
    logic        data_in;
    logic        active;
    logic        idle_out;
    logic [31:0] data_out;
    logic [3:0]  valid_out;
    logic        frame_valid;
    logic        lock_err;
    logic [1:0]  state_dbg;

    int n_cmp = 0;
    int n_err = 0;
    int lock_err_seen = 0;

    // Expected lane writes: [10] frame_valid, [9:8] lane, [7:0] byte
    logic [10:0] exp_q[$];

    phy_rx_lanes dut (
        .clk_32f    (clk_32f),
        .rst_L      (rst_L),
        .data_in    (data_in),
        .active     (active),
        .idle_out   (idle_out),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .frame_valid(frame_valid),
        .lock_err   (lock_err),
        .state_dbg  (state_dbg)
    );

    // Clock
    initial begin
        clk_32f = 1'b0;
        forever #5 clk_32f = ~clk_32f;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drivers: data_in changes 1 ns after each rising edge
    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_sym(input logic [7:0] s);
        for (int i = 7; i >= 0; i--) send_bit(s[i]);
    endtask

    task automatic send_data(input logic [7:0] s, input logic [1:0] lane, input logic frame);
        exp_q.push_back({frame, lane, s});
        send_sym(s);
    endtask

    // Scoreboard monitor: every lane write must match the head of exp_q
    always begin
        logic [10:0] e;
        int          lane;
        @(posedge clk_32f);
        #2;
        if (rst_L) begin
            if (lock_err) lock_err_seen++;
            if (valid_out != 4'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {28'b0, valid_out}, 32'b0);
                end else begin
                    e    = exp_q.pop_front();
                    lane = int'(e[9:8]);
                    check("valid_lane", {28'b0, valid_out}, 32'(4'b0001 << lane));
                    check("lane_data", {24'b0, data_out[lane*8 +: 8]}, {24'b0, e[7:0]});
                    check("frame_on_write", {31'b0, frame_valid}, {31'b0, e[10]});
                end
            end else begin
                check("frame_no_write", {31'b0, frame_valid}, 32'b0);
            end
        end
    end

    task automatic check_zero_outputs(input string pfx);
        check({pfx, "_active"}, {31'b0, active}, 32'b0);
        check({pfx, "_idle"}, {31'b0, idle_out}, 32'b0);
        check({pfx, "_data"}, data_out, 32'b0);
        check({pfx, "_valid"}, {28'b0, valid_out}, 32'b0);
        check({pfx, "_frame"}, {31'b0, frame_valid}, 32'b0);
        check({pfx, "_lock_err"}, {31'b0, lock_err}, 32'b0);
        check({pfx, "_state"}, {30'b0, state_dbg}, 32'b0);
    endtask

    initial begin
        // Reset
        rst_L   = 1'b0;
        data_in = 1'b0;
        repeat (3) @(posedge clk_32f);
        #1;
        check_zero_outputs("reset");
        rst_L = 1'b1;

        // Lock at an arbitrary bit offset
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        repeat (3) send_sym(8'hBC);
        check("lock3_active", {31'b0, active}, 32'b0);
        check("lock3_state", {30'b0, state_dbg}, 32'd1);
        send_sym(8'hBC);
        check("lock4_active", {31'b0, active}, 32'b1);
        check("lock4_state", {30'b0, state_dbg}, 32'd2);
        check("lock4_idle", {31'b0, idle_out}, 32'b0);

        // Full frame
        send_data(8'h11, 2'd0, 1'b0);
        send_data(8'h22, 2'd1, 1'b0);
        send_data(8'h33, 2'd2, 1'b0);
        send_data(8'h44, 2'd3, 1'b1);
        check("frame_pulse", {31'b0, frame_valid}, 32'b1);
        check("frame_data", data_out, 32'h44332211);

        // Idle and comma symbols between data
        send_data(8'hA5, 2'd0, 1'b0);
        check("idle_a", {31'b0, idle_out}, 32'b0);
        send_sym(8'h7C);
        check("idle_b", {31'b0, idle_out}, 32'b1);
        check("idle_b_valid", {28'b0, valid_out}, 32'b0);
        send_sym(8'hBC);
        check("idle_c", {31'b0, idle_out}, 32'b1);
        check("idle_c_active", {31'b0, active}, 32'b1);
        send_data(8'h5A, 2'd1, 1'b0);
        check("idle_d", {31'b0, idle_out}, 32'b0);
        check("idle_data", data_out, 32'h44335AA5);

        // Reset mid-frame and mid-byte
        send_data(8'h01, 2'd2, 1'b0);
        send_data(8'h02, 2'd3, 1'b1);
        send_data(8'h03, 2'd0, 1'b0);
        send_data(8'h06, 2'd1, 1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        #2;
        rst_L = 1'b0;
        #1;
        check_zero_outputs("midreset");
        repeat (2) @(posedge clk_32f);
        #1;
        rst_L = 1'b1;

        // Broken comma run restarts the count
        repeat (3) send_sym(8'hBC);
        send_sym(8'h55);
        check("break_active", {31'b0, active}, 32'b0);
        check("break_state", {30'b0, state_dbg}, 32'd0);
        repeat (3) send_sym(8'hBC);
        check("relock3_active", {31'b0, active}, 32'b0);
        send_sym(8'hBC);
        check("relock4_active", {31'b0, active}, 32'b1);
        send_data(8'h66, 2'd0, 1'b0);
        check("relock_data", data_out, 32'h00000066);

`ifdef PHY_RX_LOCK_LOSS_EN
        // Slip one bit: the misaligned boundary writes 0x5E, then the comma trips lock loss
        send_bit(1'b0);
        exp_q.push_back({1'b0, 2'd1, 8'h5E});
        send_sym(8'hBC);
        check("loss_lock_err", {31'b0, lock_err}, 32'b1);
        check("loss_active", {31'b0, active}, 32'b0);
        check("loss_idle", {31'b0, idle_out}, 32'b0);
        check("loss_state", {30'b0, state_dbg}, 32'd1);
        repeat (2) send_sym(8'hBC);
        check("loss_relock2", {31'b0, active}, 32'b0);
        send_sym(8'hBC);
        check("loss_relock3", {31'b0, active}, 32'b1);
        send_data(8'h77, 2'd0, 1'b0);
        check("loss_data", data_out, 32'h00005E77);
        check("lock_err_count", 32'(lock_err_seen), 32'd1);
`else
        check("lock_err_count", 32'(lock_err_seen), 32'd0);
`endif

        repeat (4) @(posedge clk_32f);
        #3;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
